alu_mult_unit: RTL and testbench
================================

# alu_mult_unit

Registered shift-add multiplier for the single-cycle processor's ALU multiply path (ALU SELECT 3'b100). Takes two WIDTH-bit operands, forms the two's-complement product truncated to WIDTH bits, and presents it one clock later with a ZERO flag. The datapath is built from WIDTH stages of 2:1 partial-product selection and accumulation.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 4–16.
- CLK, input, 1: rising-edge clock.
- RESET, input, 1: synchronous reset, active-high.
- IN_VALID, input, 1: operands on DATA1/DATA2 are valid this cycle.
- DATA1, input, WIDTH: multiplicand, two's complement.
- DATA2, input, WIDTH: multiplier, two's complement.
- OUT_VALID, output, 1: RESULT, ZERO and OVERFLOW are valid this cycle.
- RESULT, output, WIDTH: low WIDTH bits of DATA1 × DATA2.
- ZERO, output, 1: high when RESULT == 0.
- OVERFLOW, output, 1: present only with MULT_OVERFLOW_EN; full signed product is not representable in WIDTH bits.

## Operation
- Partial product i = DATA2[i] ? (DATA1 << i) : 0, for i = 0..WIDTH-1. Each selection is done by one mux2 instance.
- Partial products are summed modulo 2^WIDTH. Bits shifted beyond WIDTH-1 are discarded.
- The low WIDTH bits are identical for signed and unsigned interpretation, so no sign correction is applied to RESULT.
- ZERO is derived from the registered RESULT, not from the operands.
- No handshake back-pressure: a new operand pair is accepted every cycle IN_VALID is high.
- When IN_VALID is low, RESULT and ZERO hold their last values and OUT_VALID deasserts.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on RESULT/ZERO/OUT_VALID after edge N. Throughput is 1 per cycle.
- The combinational path from DATA1/DATA2 to the result register must close in one cycle at WIDTH = 8.
- Reset values: RESULT = 0, ZERO = 1, OUT_VALID = 0, OVERFLOW = 0.
- RESET has priority over IN_VALID in the same cycle. An operand pair presented in the reset cycle is dropped and produces no OUT_VALID.
- Reset asserted while a result is valid clears it on the next edge.
- Back-to-back valid inputs produce back-to-back valid outputs with no bubble.

## Configuration
- MULT_OVERFLOW_EN defined:
  - The OVERFLOW port exists.
  - A parallel 2·WIDTH-bit signed product is computed.
  - OVERFLOW is registered alongside RESULT and is high when product bits [2·WIDTH-1 : WIDTH-1] are not all equal.
- MULT_OVERFLOW_EN undefined:
  - The port and its logic are absent.
  - RESULT behaviour is unchanged.

## Structure
- Shared package alu_pkg holds:
  - default WIDTH constant ALU_WIDTH = 8;
  - ALU select code ALU_SEL_MULT = 3'b100;
  - a WIDTH-bit word typedef shared with the other ALU units.
- One sub-module, mux2, is a parameterised WIDTH-bit 2:1 mux with ports IN0, IN1, SELECT, OUT. It is combinational only and has no delay.
- The top instantiates WIDTH mux2 instances via generate, followed by an adder chain and the output register stage.

## Test plan
- 3 × 5 with IN_VALID = 1 → next cycle RESULT = 0x0F, ZERO = 0, OUT_VALID = 1.
- -3 (0xFD) × 5 → RESULT = 0xF1; with MULT_OVERFLOW_EN, OVERFLOW = 0.
- 0x10 × 0x10 → RESULT = 0x00, ZERO = 1; with MULT_OVERFLOW_EN, OVERFLOW = 1.
- -128 (0x80) × -1 (0xFF) → RESULT = 0x80; with MULT_OVERFLOW_EN, OVERFLOW = 1.
- Back-to-back pairs (7×9, 0×0x55, 0xFF×0xFF) on consecutive cycles:
  - RESULT = 0x3F, 0x00, 0x01 on consecutive cycles;
  - ZERO = 0, 1, 0.
- RESET asserted with IN_VALID = 1 and operands 4×4 → next cycle RESULT = 0, ZERO = 1, OUT_VALID = 0. After release, IN_VALID low keeps OUT_VALID = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, select codes and the common word type.
package alu_pkg;
    localparam int          ALU_WIDTH    = 8;
    localparam logic [2:0]  ALU_SEL_MULT = 3'b100;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;
endpackage

// File: rtl/alu_mult_unit_if.sv
// Operand/result bus of the ALU multiply path. OVERFLOW exists only when MULT_OVERFLOW_EN is defined.
interface alu_mult_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             IN_VALID;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic             OUT_VALID;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
`ifdef MULT_OVERFLOW_EN
    logic             OVERFLOW;
`endif

    modport master (
`ifdef MULT_OVERFLOW_EN
        input  OVERFLOW,
`endif
        output IN_VALID, DATA1, DATA2,
        input  OUT_VALID, RESULT, ZERO
    );

    modport slave (
`ifdef MULT_OVERFLOW_EN
        output OVERFLOW,
`endif
        input  IN_VALID, DATA1, DATA2,
        output OUT_VALID, RESULT, ZERO
    );
endinterface

// File: rtl/mux2.sv
// Parameterised WIDTH-bit 2:1 multiplexer, purely combinational.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic             SELECT,
    output logic [WIDTH-1:0] OUT
);
    assign OUT = SELECT ? IN1 : IN0;
endmodule

// File: rtl/alu_mult_unit.sv
// Registered shift-add multiplier, 1-cycle latency, product truncated to WIDTH bits.
// Optional OVERFLOW output enabled by defining MULT_OVERFLOW_EN.
module alu_mult_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic          CLK,
    input  logic          RESET,
    alu_mult_unit_if.slave bus
);
    logic [WIDTH-1:0][WIDTH-1:0] pp;
    logic [WIDTH:0][WIDTH-1:0]   acc;
    logic [WIDTH-1:0]            result_d, result_q;
    logic                        out_valid_q;

    // Low WIDTH bits of the product are sign-agnostic, so plain unsigned partial products suffice
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        mux2 #(.WIDTH(WIDTH)) u_mux2 (
            .IN0    ('0),
            .IN1    (bus.DATA1 << i),
            .SELECT (bus.DATA2[i]),
            .OUT    (pp[i])
        );
        assign acc[i+1] = acc[i] + pp[i];
    end
    assign acc[0]   = '0;
    assign result_d = acc[WIDTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.IN_VALID;
            if (bus.IN_VALID) result_q <= result_d;
        end
    end

    assign bus.RESULT    = result_q;
    assign bus.ZERO      = (result_q == '0);
    assign bus.OUT_VALID = out_valid_q;

`ifdef MULT_OVERFLOW_EN
    logic signed [2*WIDTH-1:0] a_ext, b_ext, full_prod;
    logic                      ovf_d, ovf_q;

    assign a_ext     = $signed({{WIDTH{bus.DATA1[WIDTH-1]}}, bus.DATA1});
    assign b_ext     = $signed({{WIDTH{bus.DATA2[WIDTH-1]}}, bus.DATA2});
    assign full_prod = a_ext * b_ext;
    // Representable iff the upper half plus the result sign bit are all copies of one bit
    assign ovf_d     = !((&full_prod[2*WIDTH-1:WIDTH-1]) || !(|full_prod[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge CLK) begin
        if (RESET)             ovf_q <= 1'b0;
        else if (bus.IN_VALID) ovf_q <= ovf_d;
    end

    assign bus.OVERFLOW = ovf_q;
`endif
endmodule

// File: tb/tb_alu_mult_unit.sv
// Directed bench for alu_mult_unit (WIDTH = 8); also checks OVERFLOW when MULT_OVERFLOW_EN is defined.
module tb_alu_mult_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_mult_unit_if #(.WIDTH(8)) bus ();

    alu_mult_unit #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input alu_word_t a, input alu_word_t b);
        bus.IN_VALID = v;
        bus.DATA1    = a;
        bus.DATA2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] res, input logic z,
                              input logic ov, input logic ovf);
        check({tag, ".result"}, {24'd0, bus.RESULT}, {24'd0, res});
        check({tag, ".zero"}, {31'd0, bus.ZERO}, {31'd0, z});
        check({tag, ".out_valid"}, {31'd0, bus.OUT_VALID}, {31'd0, ov});
`ifdef MULT_OVERFLOW_EN
        check({tag, ".overflow"}, {31'd0, bus.OVERFLOW}, {31'd0, ovf});
`else
        if (ovf === 1'bx) $display("note: ovf unused");
`endif
    endtask

    initial begin
        bus.IN_VALID = 1'b0;
        bus.DATA1    = '0;
        bus.DATA2    = '0;
        rst          = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        expect_out("reset", 8'h00, 1'b1, 1'b0, 1'b0);

        rst = 1'b0;
        step(1'b1, 8'h03, 8'h05);
        expect_out("3x5", 8'h0F, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hFD, 8'h05);
        expect_out("m3x5", 8'hF1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h10, 8'h10);
        expect_out("16x16", 8'h00, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h80, 8'hFF);
        expect_out("m128xm1", 8'h80, 1'b0, 1'b1, 1'b1);

        // Back-to-back stream, no bubble expected
        step(1'b1, 8'h07, 8'h09);
        expect_out("b2b_7x9", 8'h3F, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 8'h55);
        expect_out("b2b_0x55", 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 8'hFF);
        expect_out("b2b_m1xm1", 8'h01, 1'b0, 1'b1, 1'b0);

        // IN_VALID low: result and flags hold, OUT_VALID drops
        step(1'b0, 8'h12, 8'h34);
        expect_out("hold", 8'h01, 1'b0, 1'b0, 1'b0);

        step(1'b1, 8'hF9, 8'hFA);
        expect_out("m7xm6", 8'h2A, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h7F, 8'h7F);
        expect_out("127x127", 8'h01, 1'b0, 1'b1, 1'b1);

        // Reset has priority over a valid operand pair
        rst = 1'b1;
        step(1'b1, 8'h04, 8'h04);
        expect_out("rst_prio", 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 8'h04, 8'h04);
        expect_out("post_rst_idle", 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset while a result is valid clears it
        step(1'b1, 8'h02, 8'h03);
        expect_out("2x3", 8'h06, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        expect_out("rst_clear", 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
